// File: rtl/l3_onchip_pkg.sv
// -----------------------------------------------------------------------------
// l3_onchip_pkg
// Shared types and constants for the on-chip L2/L3 memory subsystem.
//   fill_state_e  : bank init controller FSM states
//   init_mode_e   : fill data source (constant pattern or word address)
//   L2_DATA_WIDTH : bank word width, shared with l3_onchip_subsystem
// -----------------------------------------------------------------------------
package l3_onchip_pkg;

  localparam int unsigned L2_DATA_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  typedef enum logic {
    INIT_CONST = 1'b0,
    INIT_ADDR  = 1'b1
  } init_mode_e;

endpackage : l3_onchip_pkg

// File: rtl/l3_bank_init_ctrl.sv
// -----------------------------------------------------------------------------
// l3_bank_init_ctrl
// Per-bank controller between one interconnect output port and one SRAM bank
// (1-cycle read latency). It owns the bank port and arbitrates between the
// interconnect and an internal fill engine that writes every word of the bank
// with either a constant pattern or the word's own address.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   init_req_i/_mode_i/_pattern_i fill request (sampled only when idle)
//   init_busy_o, init_done_o      fill running / one-cycle completion pulse
//   req_i, gnt_o, add_i, wen_i,
//   wdata_i, be_i, vld_o, rdata_o interconnect side (wen_i = 1 means read)
//   mem_*_o, mem_rdata_i          SRAM bank side (mem_we_o active high)
// -----------------------------------------------------------------------------
module l3_bank_init_ctrl
  import l3_onchip_pkg::*;
#(
  parameter int unsigned          NumWords     = 32768,
  parameter int unsigned          AddrWidth    = $clog2(NumWords),
  parameter int unsigned          DataWidth    = L2_DATA_WIDTH,
  parameter logic                 InitOnReset  = 1'b1,
  parameter logic [DataWidth-1:0] ResetPattern = {DataWidth{1'b0}}
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  // fill control
  input  logic                   init_req_i,
  input  logic                   init_mode_i,
  input  logic [DataWidth-1:0]   init_pattern_i,
  output logic                   init_busy_o,
  output logic                   init_done_o,
  // interconnect side
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [AddrWidth-1:0]   add_i,
  input  logic                   wen_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] be_i,
  output logic                   vld_o,
  output logic [DataWidth-1:0]   rdata_o,
  // SRAM bank side
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  input  logic [DataWidth-1:0]   mem_rdata_i
);

  localparam int unsigned    BeWidth    = DataWidth / 8;
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);
  localparam fill_state_e    ResetState = InitOnReset ? FILL : IDLE;

  fill_state_e          state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;
  logic [DataWidth-1:0] pattern_q, pattern_d;
  init_mode_e           mode_q, mode_d;
  logic                 done_q, done_d;
  logic                 vld_q, vld_d;

  logic                 fill_last_s;
  logic [DataWidth-1:0] fill_data_s;
  logic                 gnt_s;

  // The last fill write is the one addressing the final bank word; NumWords
  // need not be a power of two, so the wrap is an explicit compare.
  assign fill_last_s = (state_q == FILL) && (cnt_q == LastAddr);
  assign fill_data_s = (mode_q == INIT_ADDR) ? DataWidth'(cnt_q) : pattern_q;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ResetState;
    end else begin
      state_q <= state_d;
    end
  end

  // Fill counter, latched fill settings and registered status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= {AddrWidth{1'b0}};
      pattern_q <= ResetPattern;
      mode_q    <= INIT_CONST;
      done_q    <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pattern_q <= pattern_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      vld_q     <= vld_d;
    end
  end

  // Next-state logic: accept a fill request when idle, walk the bank when filling
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pattern_d = pattern_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_req_i) begin
          state_d   = FILL;
          cnt_d     = {AddrWidth{1'b0}};
          pattern_d = init_pattern_i;
          mode_d    = init_mode_e'(init_mode_i);
        end else begin
          state_d   = IDLE;
        end
      end
      FILL: begin
        // Further init requests are deliberately not looked at here.
        if (fill_last_s) begin
          state_d = IDLE;
          cnt_d   = {AddrWidth{1'b0}};
          done_d  = 1'b1;
        end else begin
          state_d = FILL;
          cnt_d   = cnt_q + AddrWidth'(1);
        end
      end
      default: begin
        state_d = ResetState;
        cnt_d   = {AddrWidth{1'b0}};
      end
    endcase
  end

  // Output logic: bank port mux between interconnect and fill engine.
  // Grant and bank request are held off while reset is asserted.
  always_comb begin
    gnt_s       = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = cnt_q;
    mem_wdata_o = pattern_q;
    mem_be_o    = {BeWidth{1'b0}};
    case (state_q)
      IDLE: begin
        // A request arriving together with init_req_i is still served here.
        gnt_s       = req_i & rst_ni;
        mem_req_o   = req_i & rst_ni;
        mem_we_o    = ~wen_i;
        mem_addr_o  = add_i;
        mem_wdata_o = wdata_i;
        mem_be_o    = be_i;
      end
      FILL: begin
        gnt_s       = 1'b0;
        mem_req_o   = rst_ni;
        mem_we_o    = 1'b1;
        mem_addr_o  = cnt_q;
        mem_wdata_o = fill_data_s;
        mem_be_o    = {BeWidth{1'b1}};
      end
      default: begin
        gnt_s       = 1'b0;
        mem_req_o   = 1'b0;
      end
    endcase
    vld_d = gnt_s;
  end

  assign gnt_o       = gnt_s;
  assign vld_o       = vld_q;
  assign init_busy_o = (state_q == FILL);
  assign init_done_o = done_q;
  // Read data comes straight from the bank; it never feeds control logic.
  assign rdata_o     = mem_rdata_i;

endmodule : l3_bank_init_ctrl
